// File: rtl/adder_pkg.sv
// Shared types and sizing for the nibble-serial adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int SLICE_W = 4;
  localparam int WIDTH   = 16;
  localparam int NSLICE  = WIDTH / SLICE_W;
  localparam int CNT_W   = $clog2(NSLICE);

  // Counter width for an arbitrary operand width; never narrower than 1 bit.
  function automatic int cnt_width(input int w);
    return (w / SLICE_W > 1) ? $clog2(w / SLICE_W) : 1;
  endfunction

endpackage

// File: rtl/slice_adder4.sv
// Combinational 4-bit ripple slice; c3 is the carry into bit 3, used for signed overflow.
module slice_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);

  logic [3:0] lo;
  logic [1:0] hi;

  assign lo   = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
  assign c3   = lo[3];
  assign hi   = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, c3};
  assign s    = {hi[0], lo[2:0]};
  assign cout = hi[1];

endmodule

// File: rtl/serial_addsub16.sv
// Nibble-serial adder/subtractor: one 4-bit slice per cycle, LSB nibble first.
// Results, flags and busy/done are registered; a new request is accepted in IDLE or DONE.
module serial_addsub16
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int NS = WIDTH / SLICE_W;
  localparam int CW = cnt_width(WIDTH);

  state_t               state;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [WIDTH-1:0]     res;
  logic [WIDTH-1:0]     res_nxt;
  logic                 carry;
  logic [CW-1:0]        cnt;
  logic [SLICE_W-1:0]   sl_s;
  logic                 sl_co;
  logic                 sl_c3;

  slice_adder4 u_slice (
    .a    (a_reg[SLICE_W-1:0]),
    .b    (b_reg[SLICE_W-1:0]),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_co),
    .c3   (sl_c3)
  );

  // New slice enters at the top; after NS shifts the result is aligned.
  assign res_nxt = WIDTH'({sl_s, res} >> SLICE_W);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction as A + ~B + 1: the +1 rides in on the initial carry.
            a_reg <= A;
            b_reg <= sub ? ~B : B;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_reg <= a_reg >> SLICE_W;
          b_reg <= b_reg >> SLICE_W;
          res   <= res_nxt;
          carry <= sl_co;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NS - 1)) begin
            S     <= res_nxt;
            cout  <= sl_co;
            ovf   <= sl_c3 ^ sl_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
